// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and their downstream users.
// Pure functions, no latency (elaborate to combinational logic).
// No flow control; callers size arguments through GRAY_MAX_W zero-extension.
package gray_pkg;

  // Widest counter the helpers cover; narrower values are zero-extended.
  localparam int GRAY_MAX_W = 32;

  // Binary to reflected Gray: g[i] = b[i+1] ^ b[i], top bit passes through.
  // Zero-extension makes the result correct for any width <= GRAY_MAX_W.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray back to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // MAX_CNT helper: all-ones count for a counter of width w.
  function automatic logic [GRAY_MAX_W-1:0] max_cnt(input int w);
    logic [63:0] one_past;
    one_past = 64'd1 << w;
    return GRAY_MAX_W'(one_past - 64'd1);
  endfunction

endpackage

// File: rtl/gray_counter_param_if.sv
// Control and result bundle for gray_counter_param.
// No latency of its own; just wires.
// No backpressure; the counter accepts a command every cycle.
interface gray_counter_param_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             tc;
  logic             wrap;

  // Controller side: issues commands, observes the count.
  modport master (
    output clr, load, load_val, en, up_dn,
    input  bin_q, gray_q, tc, wrap
  );

  // Counter side.
  modport slave (
    input  clr, load, load_val, en, up_dn,
    output bin_q, gray_q, tc, wrap
  );
endinterface

// File: rtl/bin_to_gray_comb.sv
// Binary-to-Gray converter of arbitrary width.
// Zero latency, purely combinational.
// No flow control.
module bin_to_gray_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Each Gray bit marks a change between adjacent binary bits; MSB is copied.
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter_param.sv
// Up/down binary counter with registered Gray output, clear and parallel load.
// One cycle: commands take effect on the next rising clk edge; tc is combinational.
// No backpressure. Optional GRAY_CNT_SATURATE_EN: stop at the ends instead of wrapping.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int unsigned INIT  = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  gray_counter_param_if.slave bus
);

  localparam logic [WIDTH-1:0] TOP_VAL  = WIDTH'(max_cnt(WIDTH));
  localparam logic [WIDTH-1:0] INIT_BIN = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRY = WIDTH'(bin2gray(GRAY_MAX_W'(INIT_BIN)));

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_nxt;
  logic             wrap_r;
  logic             at_top;
  logic             at_bot;

  assign at_top = (cnt == TOP_VAL);
  assign at_bot = (cnt == '0);

  // Next count by priority clr > load > en > hold; wrap only on a counted rollover.
  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (bus.clr) begin
      cnt_nxt = INIT_BIN;
    end else if (bus.load) begin
      cnt_nxt = bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_top) begin
`ifdef GRAY_CNT_SATURATE_EN
          cnt_nxt  = cnt;
`else
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
`ifdef GRAY_CNT_SATURATE_EN
          cnt_nxt  = cnt;
`else
          cnt_nxt  = TOP_VAL;
          wrap_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
    end
  end

  // Gray is encoded from the next count so the Gray register itself is glitch-free.
  bin_to_gray_comb #(.WIDTH(WIDTH)) u_b2g (
    .bin  (cnt_nxt),
    .gray (gray_nxt)
  );

  // Binary, Gray and wrap registers all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= INIT_BIN;
      gray_r <= INIT_GRY;
      wrap_r <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      gray_r <= gray_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign bus.bin_q  = cnt;
  assign bus.gray_q = gray_r;
  assign bus.wrap   = wrap_r;
  // Terminal count tracks the current direction so it flags the end we are heading to.
  assign bus.tc     = bus.up_dn ? at_top : at_bot;

endmodule

// File: tb/tb_gray_counter_param.sv
// Self-checking bench for gray_counter_param (WIDTH=4, INIT=0 and INIT=6).
// Directed steps followed by a randomized run against an arithmetic model.
// Optional GRAY_CNT_SATURATE_EN switches the model and the saturation steps.
module tb_gray_counter_param;

  logic clk;
  logic rst_n;
  logic rst6_n;

  gray_counter_param_if #(.WIDTH(4)) bus ();
  gray_counter_param_if #(.WIDTH(4)) bus6 ();

  gray_counter_param #(.WIDTH(4), .INIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  gray_counter_param #(.WIDTH(4), .INIT(6)) dut6 (
    .clk   (clk),
    .rst_n (rst6_n),
    .bus   (bus6.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int passed;
  int gtab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int m;
    int ew;
    int prev_g;
    logic c, l, e, u;
    logic [3:0] lv;

    total  = 0;
    passed = 0;

    // Reflected Gray table built by mirroring: second half = mirrored first half + new top bit.
    gtab[0] = 0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < (1 << k); j++) begin
        gtab[(1 << k) + j] = gtab[(1 << k) - 1 - j] | (1 << k);
      end
    end

    bus.clr = 0;  bus.load = 0;  bus.load_val = '0;  bus.en = 0;  bus.up_dn = 0;
    bus6.clr = 0; bus6.load = 0; bus6.load_val = '0; bus6.en = 0; bus6.up_dn = 1;
    rst_n  = 1'b1;
    rst6_n = 1'b1;
    #1;
    rst_n  = 1'b0;
    rst6_n = 1'b0;
    #1;

    // Reset state
    chk("rst_bin", bus.bin_q, 0);
    chk("rst_gray", bus.gray_q, 0);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_tc_dn", bus.tc, 1);
    chk("rst6_bin", bus6.bin_q, 6);
    chk("rst6_gray", bus6.gray_q, 4'b0101);
    chk("rst6_wrap", bus6.wrap, 0);

    @(negedge clk);
    rst_n  = 1'b1;
    rst6_n = 1'b1;
    #1;
    chk("hold_after_rst", bus.bin_q, 0);

    // Count up 16 steps through the wrap
    bus.en = 1; bus.up_dn = 1;
    prev_g = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      m = i % 16;
      chk("up_bin", bus.bin_q, m);
      chk("up_gray", bus.gray_q, gtab[m]);
      chk("up_onebit", $countones(bus.gray_q ^ prev_g[3:0]), 1);
      chk("up_wrap", bus.wrap, (m == 0) ? 1 : 0);
      if (m == 5)  chk("gray_at5", bus.gray_q, 4'b0111);
      if (m == 6)  chk("gray_at6", bus.gray_q, 4'b0101);
      if (m == 15) chk("gray_at15", bus.gray_q, 4'b1000);
      prev_g = int'(bus.gray_q);
    end

    // Count down from 0
    bus.up_dn = 0;
    #1;
    chk("tc_dn_at0", bus.tc, 1);
    step();
`ifdef GRAY_CNT_SATURATE_EN
    chk("dn0_bin_sat", bus.bin_q, 0);
    chk("dn0_wrap_sat", bus.wrap, 0);
`else
    chk("dn0_bin", bus.bin_q, 15);
    chk("dn0_gray", bus.gray_q, 4'b1000);
    chk("dn0_wrap", bus.wrap, 1);
`endif

    // Load beats count
    bus.load = 1; bus.load_val = 4'd9; bus.en = 1; bus.up_dn = 1;
    step();
    chk("load_bin", bus.bin_q, 9);
    chk("load_gray", bus.gray_q, 4'b1101);
    chk("load_wrap", bus.wrap, 0);

    // Clear beats load and count
    bus.clr = 1;
    step();
    chk("clr_bin", bus.bin_q, 0);
    chk("clr_gray", bus.gray_q, 0);
    chk("clr_wrap", bus.wrap, 0);

    // Reloading the current value
    bus.clr = 0; bus.load_val = 4'd0;
    step();
    chk("reload_bin", bus.bin_q, 0);
    chk("reload_wrap", bus.wrap, 0);
    bus.load = 0; bus.en = 0;

`ifdef GRAY_CNT_SATURATE_EN
    bus.load = 1; bus.load_val = 4'd14;
    step();
    bus.load = 0; bus.en = 1; bus.up_dn = 1;
    step();
    chk("sat_up_15", bus.bin_q, 15);
    step();
    chk("sat_up_hold", bus.bin_q, 15);
    chk("sat_up_gray", bus.gray_q, 4'b1000);
    chk("sat_up_tc", bus.tc, 1);
    chk("sat_up_wrap", bus.wrap, 0);
    bus.load = 1; bus.load_val = 4'd1; bus.en = 0;
    step();
    bus.load = 0; bus.en = 1; bus.up_dn = 0;
    step();
    chk("sat_dn_0", bus.bin_q, 0);
    step();
    chk("sat_dn_hold", bus.bin_q, 0);
    chk("sat_dn_wrap", bus.wrap, 0);
    bus.en = 0;
`endif

    // INIT=6 instance: count, then an async reset pulse between clock edges
    bus6.en = 1;
    step();
    chk("i6_cnt7", bus6.bin_q, 7);
    step();
    chk("i6_cnt8", bus6.bin_q, 8);
    #2;
    rst6_n = 1'b0;
    #1;
    chk("i6_async_bin", bus6.bin_q, 6);
    chk("i6_async_gray", bus6.gray_q, 4'b0101);
    chk("i6_async_wrap", bus6.wrap, 0);
    #2;
    rst6_n = 1'b1;
    step();
    chk("i6_after_rst", bus6.bin_q, 7);
    bus6.en = 0;

    // Randomized run against the arithmetic model
    m = int'(bus.bin_q);
    for (int n = 0; n < 1000; n++) begin
      c  = ($urandom_range(15) == 0);
      l  = ($urandom_range(7) == 0);
      e  = ($urandom_range(3) != 0);
      u  = $urandom_range(1);
      lv = 4'($urandom_range(15));
      bus.clr = c; bus.load = l; bus.en = e; bus.up_dn = u; bus.load_val = lv;
      #1;
      chk("rnd_tc", bus.tc, (u ? (m == 15) : (m == 0)) ? 1 : 0);
      ew = 0;
      if (c) m = 0;
      else if (l) m = int'(lv);
      else if (e) begin
        if (u) begin
          if (m == 15) begin
`ifdef GRAY_CNT_SATURATE_EN
            m = 15;
`else
            m = 0; ew = 1;
`endif
          end else m = m + 1;
        end else begin
          if (m == 0) begin
`ifdef GRAY_CNT_SATURATE_EN
            m = 0;
`else
            m = 15; ew = 1;
`endif
          end else m = m - 1;
        end
      end
      step();
      chk("rnd_bin", bus.bin_q, m);
      chk("rnd_gray", bus.gray_q, gtab[m]);
      chk("rnd_wrap", bus.wrap, ew);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
